// File: rtl/irrigation_pkg.sv
// irrigation_pkg
//   Shared definitions for the irrigation scheduler: moisture class
//   encodings, classification thresholds and the scan FSM state type.
//   No ports.
package irrigation_pkg;

    localparam logic [1:0] CLS_DRY = 2'b00;
    localparam logic [1:0] CLS_OPT = 2'b01;
    localparam logic [1:0] CLS_WET = 2'b10;

    // Inclusive upper bounds on the raw 10-bit ADC reading
    localparam int DRY_MAX = 350;
    localparam int OPT_MAX = 700;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        NEXT,
        DECIDE
    } state_t;

endpackage

// File: rtl/moisture_classifier.sv
// moisture_classifier
//   Purely combinational mapping of one 10-bit moisture sample to a class.
//   Ports:
//     data  in  10  raw moisture sample
//     cls   out 2   CLS_DRY / CLS_OPT / CLS_WET
module moisture_classifier
    import irrigation_pkg::*;
(
    input  logic [9:0] data,
    output logic [1:0] cls
);

    always_comb begin
        if (data <= 10'(DRY_MAX))
            cls = CLS_DRY;
        else if (data <= 10'(OPT_MAX))
            cls = CLS_OPT;
        else
            cls = CLS_WET;
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Multi-zone irrigation sequencer. Each scan_tick polls every zone's
//   moisture ADC over a req/ack handshake, records the class per zone, then
//   spends one DECIDE cycle scheduling the single shared pump/valve.
//
//   Build option: IRRIG_DEEP_WATER_EN -- when defined an episode ends only
//   on a Wet reading; otherwise any non-Dry reading ends it.
//
//   Ports:
//     clk        in   1            system clock
//     rst        in   1            synchronous active-high reset
//     scan_tick  in   1            starts a scan; dropped while busy
//     adc_req    out  1            sample request, held until ack/timeout
//     adc_zone   out  3            zone selected on the ADC mux
//     adc_ack    in   1            sample strobe, adc_data valid with it
//     adc_data   in   10           moisture sample
//     valve      out  NUM_ZONES    one-hot or zero valve drive
//     pump_on    out  1            pump enable, always equal to |valve
//     zone_class out  2*NUM_ZONES  last class per zone
//     zone_fault out  NUM_ZONES    sticky over-watering fault
//     adc_err    out  1            one-cycle pulse on ADC timeout
//     busy       out  1            scan in progress
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES    = 4,
    parameter int ADC_TIMEOUT  = 64,
    parameter int MAX_ON_SCANS = 10,
    parameter int REST_SCANS   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_tick,
    output logic                   adc_req,
    output logic [2:0]             adc_zone,
    input  logic                   adc_ack,
    input  logic [9:0]             adc_data,
    output logic [NUM_ZONES-1:0]   valve,
    output logic                   pump_on,
    output logic [2*NUM_ZONES-1:0] zone_class,
    output logic [NUM_ZONES-1:0]   zone_fault,
    output logic                   adc_err,
    output logic                   busy
);

    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int WW = $clog2(ADC_TIMEOUT + 1);
    localparam int OW = $clog2(MAX_ON_SCANS + 1);
    localparam int RW = (REST_SCANS > 0) ? $clog2(REST_SCANS + 1) : 1;

    state_t state, state_nx;

    logic [ZW-1:0]                z;          // zone being sampled
    logic [ZW-1:0]                w;          // zone being watered
    logic                         watering;
    logic [WW-1:0]                wait_cnt;
    logic [OW-1:0]                on_cnt;     // scans watered since the valve opened
    logic [RW-1:0]                rest_cnt;
    logic [NUM_ZONES-1:0][1:0]    cls_q;
    logic [1:0]                   sample_cls;
    logic                         timeout;
    logic                         last_zone;
    logic                         episode_done;
    logic                         pick_vld;
    logic [ZW-1:0]                pick_idx;

    moisture_classifier u_cls (
        .data (adc_data),
        .cls  (sample_cls)
    );

    assign adc_zone   = 3'(z);
    assign zone_class = cls_q;
    assign last_zone  = (z == ZW'(NUM_ZONES - 1));
    // An ack in the final wait cycle wins over the timeout
    assign timeout    = (wait_cnt == WW'(ADC_TIMEOUT - 1)) && !adc_ack;

`ifdef IRRIG_DEEP_WATER_EN
    assign episode_done = (cls_q[w] == CLS_WET);
`else
    assign episode_done = (cls_q[w] != CLS_DRY);
`endif

    // Lowest-index Dry, unfaulted zone: scan downward so the lowest hit wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (cls_q[i] == CLS_DRY && !zone_fault[i]) begin
                pick_vld = 1'b1;
                pick_idx = ZW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        adc_req  = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (scan_tick)
                    state_nx = REQ;
            end
            REQ: begin
                adc_req = 1'b1;
                busy    = 1'b1;
                if (adc_ack || timeout)
                    state_nx = NEXT;
            end
            NEXT: begin
                busy     = 1'b1;
                state_nx = last_zone ? DECIDE : REQ;
            end
            DECIDE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z          <= '0;
            w          <= '0;
            watering   <= 1'b0;
            wait_cnt   <= '0;
            on_cnt     <= '0;
            rest_cnt   <= '0;
            cls_q      <= {NUM_ZONES{CLS_OPT}};
            valve      <= '0;
            pump_on    <= 1'b0;
            zone_fault <= '0;
            adc_err    <= 1'b0;
        end else begin
            adc_err <= 1'b0;
            case (state)
                IDLE: begin
                    z        <= '0;
                    wait_cnt <= '0;
                end
                REQ: begin
                    if (adc_ack) begin
                        cls_q[z] <= sample_cls;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        adc_err  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_zone)
                        z <= z + 1'b1;
                end
                DECIDE: begin
                    if (watering) begin
                        if (episode_done) begin
                            watering <= 1'b0;
                            valve    <= '0;
                            pump_on  <= 1'b0;
                            rest_cnt <= RW'(REST_SCANS);
                        end else if (on_cnt == OW'(MAX_ON_SCANS - 1)) begin
                            // This scan completes MAX_ON_SCANS of watering
                            zone_fault[w] <= 1'b1;
                            watering      <= 1'b0;
                            valve         <= '0;
                            pump_on       <= 1'b0;
                            rest_cnt      <= RW'(REST_SCANS);
                        end else begin
                            on_cnt <= on_cnt + 1'b1;
                        end
                    end else if (rest_cnt != '0) begin
                        rest_cnt <= rest_cnt - 1'b1;
                    end else if (pick_vld) begin
                        watering <= 1'b1;
                        w        <= pick_idx;
                        valve    <= NUM_ZONES'(1) << pick_idx;
                        pump_on  <= 1'b1;
                        on_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler
//   Directed bench for irrigation_scheduler: a negedge ADC responder serves
//   samples from a per-zone table (or withholds ack), scans are launched
//   one at a time and outputs compared against hand-computed values.
module tb_irrigation_scheduler;

    localparam int NZ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_tick;
    logic          adc_req;
    logic [2:0]    adc_zone;
    logic          adc_ack = 1'b0;
    logic [9:0]    adc_data = '0;
    logic [NZ-1:0] valve;
    logic          pump_on;
    logic [2*NZ-1:0] zone_class;
    logic [NZ-1:0] zone_fault;
    logic          adc_err;
    logic          busy;

    logic [9:0] mdata [8];
    logic       withhold [8];

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int req1_cnt = 0;
    int busy_cyc;
    int err0, req0;

    always #5 clk = ~clk;

    irrigation_scheduler #(
        .NUM_ZONES   (NZ),
        .ADC_TIMEOUT (64),
        .MAX_ON_SCANS(10),
        .REST_SCANS  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_tick  (scan_tick),
        .adc_req    (adc_req),
        .adc_zone   (adc_zone),
        .adc_ack    (adc_ack),
        .adc_data   (adc_data),
        .valve      (valve),
        .pump_on    (pump_on),
        .zone_class (zone_class),
        .zone_fault (zone_fault),
        .adc_err    (adc_err),
        .busy       (busy)
    );

    // ADC model: acks one cycle after the request is seen
    always @(negedge clk) begin
        if (adc_req && !adc_ack && !withhold[adc_zone]) begin
            adc_ack  = 1'b1;
            adc_data = mdata[adc_zone];
        end else begin
            adc_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (adc_err) err_cnt++;
        if (adc_req && adc_zone == 3'd1) req1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [NZ-1:0] v, input logic p);
        chk({tag, "_valve"}, 32'(valve), 32'(v));
        chk({tag, "_pump"}, 32'(pump_on), 32'(p));
        chk({tag, "_inv"}, 32'((pump_on == |valve) && $onehot0(valve)), 32'd1);
    endtask

    task automatic do_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic set_all(input logic [9:0] v);
        for (int i = 0; i < 8; i++) begin
            mdata[i]    = v;
            withhold[i] = 1'b0;
        end
    endtask

    // Launch one scan and wait for busy to drop; extra re-pulses scan_tick mid-scan
    task automatic scan(input bit extra);
        int guard;
        @(negedge clk); scan_tick = 1'b1;
        @(negedge clk); scan_tick = 1'b0;
        busy_cyc = 0;
        guard    = 0;
        while (busy && guard < 500) begin
            busy_cyc++;
            guard++;
            scan_tick = extra && (busy_cyc == 3);
            @(negedge clk);
        end
        scan_tick = 1'b0;
        if (guard >= 500) chk("scan_hang", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        scan_tick = 1'b0;
        set_all(10'd500);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk_out("rst", 4'b0000, 1'b0);
        chk("rst_class", 32'(zone_class), 32'h55);
        chk("rst_fault", 32'(zone_fault), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(adc_req), 32'd0);
        chk("rst_zone", 32'(adc_zone), 32'd0);
        chk("rst_err", 32'(adc_err), 32'd0);

        // All Optimal; a tick during busy must not start a second scan
        scan(1'b1);
        chk("opt_busy_cyc", 32'(busy_cyc), 32'd9);
        chk("opt_class", 32'(zone_class), 32'h55);
        chk_out("opt", 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        chk("drop_tick_busy", 32'(busy), 32'd0);

        // Zone 2 dry, then satisfied, then rest period
        mdata[2] = 10'd200;
        scan(1'b0);
        chk("z2_class", 32'(zone_class), 32'h45);
        chk_out("z2_open", 4'b0100, 1'b1);
        mdata[2] = 10'd600;
        scan(1'b0);
        chk_out("z2_close", 4'b0000, 1'b0);
        mdata[2] = 10'd200;
        for (int k = 0; k < 2; k++) begin
            scan(1'b0);
            chk_out("z2_rest", 4'b0000, 1'b0);
        end
        scan(1'b0);
        chk_out("z2_reopen", 4'b0100, 1'b1);

        // Zones 1 and 3 dry: lowest index wins, zone 3 waits for rest
        do_rst();
        set_all(10'd500);
        mdata[1] = 10'd100;
        mdata[3] = 10'd100;
        scan(1'b0);
        chk("z13_class", 32'(zone_class), 32'h11);
        chk_out("z13_pick", 4'b0010, 1'b1);
        scan(1'b0);
        chk_out("z13_hold", 4'b0010, 1'b1);
        mdata[1] = 10'd500;
        scan(1'b0);
        chk_out("z13_close", 4'b0000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            scan(1'b0);
            chk_out("z13_rest", 4'b0000, 1'b0);
        end
        scan(1'b0);
        chk_out("z13_z3", 4'b1000, 1'b1);

        // Zone 0 stays dry: fault at the 11th DECIDE
        do_rst();
        set_all(10'd500);
        mdata[0] = 10'd100;
        for (int k = 1; k <= 10; k++) begin
            scan(1'b0);
            chk_out("z0_water", 4'b0001, 1'b1);
            chk("z0_nofault", 32'(zone_fault), 32'h0);
        end
        scan(1'b0);
        chk("z0_fault", 32'(zone_fault), 32'h1);
        chk_out("z0_fault", 4'b0000, 1'b0);
        mdata[2] = 10'd100;
        for (int k = 0; k < 2; k++) begin
            scan(1'b0);
            chk_out("z0_rest", 4'b0000, 1'b0);
        end
        scan(1'b0);
        chk_out("z0_skip", 4'b0100, 1'b1);
        do_rst();
        chk("fault_clear", 32'(zone_fault), 32'h0);

        // ADC timeout on zone 1
        set_all(10'd500);
        mdata[1] = 10'd800;
        scan(1'b0);
        chk("to_pre_class", 32'(zone_class), 32'h59);
        mdata[1]    = 10'd200;
        withhold[1] = 1'b1;
        mdata[2]    = 10'd100;
        err0 = err_cnt;
        req0 = req1_cnt;
        scan(1'b0);
        chk("to_err_pulses", 32'(err_cnt - err0), 32'd1);
        chk("to_req_cycles", 32'(req1_cnt - req0), 32'd64);
        chk("to_busy_cyc", 32'(busy_cyc), 32'd72);
        chk("to_class", 32'(zone_class), 32'h49);
        chk_out("to_pick", 4'b0100, 1'b1);

        // Reset mid-scan while zone 0 waters
        do_rst();
        set_all(10'd500);
        mdata[0] = 10'd100;
        scan(1'b0);
        chk_out("mid_pre", 4'b0001, 1'b1);
        @(negedge clk); scan_tick = 1'b1;
        @(negedge clk); scan_tick = 1'b0;
        chk("mid_req_lat", 32'(adc_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_out("mid_rst", 4'b0000, 1'b0);
        chk("mid_rst_req", 32'(adc_req), 32'd0);
        chk("mid_rst_class", 32'(zone_class), 32'h55);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Multi-zone irrigation sequencer built on the soil-moisture classifier.
- On each scan tick it polls every zone's 10-bit moisture ADC over a req/ack handshake and classifies each sample as Dry, Optimal or Wet.
- It schedules one shared pump so that at most one zone valve is open at a time, and enforces a maximum watering time and a pump rest time.
- It sits between the ADC front end and the valve/pump drivers.

Parameters:
- NUM_ZONES, 4: number of zones; range 2..8.
- ADC_TIMEOUT, 64: clk cycles to wait for adc_ack before abandoning a sample.
- MAX_ON_SCANS, 10: maximum consecutive scans one zone may water before it is faulted.
- REST_SCANS, 2: scans the pump must stay off after a watering episode ends.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scan_tick  in  1  one-cycle pulse that starts a scan; ignored while busy.
- adc_req  out  1  sample request; held until ack or timeout.
- adc_zone  out  3  zone index for the ADC mux; stable while adc_req is high.
- adc_ack  in  1  one-cycle pulse; adc_data is valid in the same cycle.
- adc_data  in  10  moisture sample.
- valve  out  NUM_ZONES  one-hot or zero; one bit per zone valve.
- pump_on  out  1  pump enable.
- zone_class  out  2*NUM_ZONES  last class per zone, zone i at bits [2i+1:2i]; 00 Dry, 01 Optimal, 10 Wet.
- zone_fault  out  NUM_ZONES  sticky over-watering fault per zone.
- adc_err  out  1  one-cycle pulse on an ADC timeout.
- busy  out  1  high while a scan is in progress.

Behaviour:
- Reset values: adc_req 0, adc_zone 0, valve 0, pump_on 0, zone_class all 01 (Optimal), zone_fault 0, adc_err 0, busy 0. All counters clear and the FSM goes to IDLE.
- Reset is synchronous and active-high. Asserting it mid-scan or mid-watering closes the valve and stops the pump on the next clock edge.
- Classification thresholds:
  - adc_data <= 350 gives Dry.
  - adc_data <= 700 gives Optimal.
  - Otherwise Wet.
- State IDLE: on scan_tick, set zone index z=0, set busy=1, go to REQ.
- State REQ: adc_req=1 and adc_zone=z.
  - On adc_ack: register the class into zone_class[z], drop adc_req, go to NEXT.
  - If the wait counter reaches ADC_TIMEOUT without an ack: pulse adc_err, leave zone_class[z] unchanged, go to NEXT.
- adc_req falls in the cycle after the ack. Min latency from scan_tick to adc_req is 1 cycle.
- State NEXT: if z==NUM_ZONES-1, go to DECIDE; otherwise z++ and go to REQ.
- State DECIDE (one cycle), then IDLE with busy=0:
  - Watering zone w, if its class is not Dry: end the episode, clear valve/pump, load the rest counter with REST_SCANS.
  - Else, if w has watered for MAX_ON_SCANS scans: set zone_fault[w], end the episode, load the rest counter.
  - Else: increment w's on-scan count.
  - No zone watering and rest counter==0: pick the lowest-index zone that is Dry and not faulted, set valve[z] and pump_on=1, clear its on-scan count.
  - No zone watering and rest counter>0: decrement the rest counter and start nothing.
- valve and pump_on change only in the DECIDE cycle, and always in the same cycle as each other.
- Invariant: pump_on == |valve, and valve is never more than one-hot.
- scan_tick arriving while busy is dropped, not queued.
- zone_fault bits clear only on rst.

Optional Feature:
- Macro: IRRIG_DEEP_WATER_EN.
- When defined: a watering episode ends only when the zone reads Wet. Optimal keeps watering, subject to the MAX_ON_SCANS limit.
- When undefined: an episode ends on any non-Dry class (Optimal or Wet).

Decomposition:
- Package irrigation_pkg holds:
  - class encodings CLS_DRY=2'b00, CLS_OPT=2'b01, CLS_WET=2'b10.
  - threshold constants DRY_MAX=350 and OPT_MAX=700.
  - FSM state enum IDLE, REQ, NEXT, DECIDE.
- Sub-module: instantiate moisture_classifier combinationally on adc_data. Its class output is the value registered on ack.

Test Plan:
- Four zones all read 500: one scan gives zone_class=01 for every zone, valve=0, pump_on=0, busy high for exactly one scan.
- Zone 2 reads 200 and the rest read 500: after DECIDE, valve=0100 and pump_on=1. The next scan with zone 2 reading 600 gives valve=0 and pump_on=0. The following 2 scans with zone 2 back at 200 keep the pump off; the 3rd scan reopens the valve.
- Zones 1 and 3 read 100: valve=0010 (lowest index wins). Zone 3 stays unwatered until zone 1 is satisfied and REST_SCANS have elapsed.
- Zone 0 holds at 100 for 11 scans: zone_fault[0]=1 at the 11th DECIDE, valve=0. Zone 0 is never reselected afterwards; a rst clears the fault.
- adc_ack withheld for zone 1: adc_err pulses once after 64 cycles, zone_class[1] is unchanged, and the scan continues to zone 2.
- rst asserted while valve=0001: the next edge gives valve=0, pump_on=0, adc_req=0, zone_class all 01. A scan_tick asserted during busy produces no second scan.
